mdu_sequencer: RTL

- Iterative multiply/divide sequencer that owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Sits in the EX stage beside the ALU. It accepts an operation from ID/EX and runs it over DATA_WIDTH+1 cycles.
- While busy, it raises a stall request to the hazard unit whenever a dependent HI/LO access arrives.

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_iter_step.sv | 45 ++++
 rtl/mdu_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : mdu_pkg                                                 |
// | Description : Shared types and constants for the multiply/divide unit |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package mdu_pkg;

    localparam int MDU_MAX_WIDTH = 64;

    // Sliced down to DATA_WIDTH by the user; divide-by-zero LO value.
    localparam logic [MDU_MAX_WIDTH-1:0] MDU_DIV0_LO = '1;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t op_in);
        return (op_in == MDU_DIV) || (op_in == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t op_in);
        return (op_in == MDU_MULT) || (op_in == MDU_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : mdu_iter_step                                           |
// | Description : One shift-add multiply or restoring divide iteration    |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module mdu_iter_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] acc_in,
    input  logic [DATA_WIDTH-1:0]   operand,
    input  logic                    is_div,
    output logic [2*DATA_WIDTH-1:0] acc_out
);

    logic [DATA_WIDTH-1:0] hi_in;
    logic [DATA_WIDTH-1:0] lo_in;
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic                  div_fits;
    logic [DATA_WIDTH-1:0] rem_sub;

    // Multiply: LO holds the remaining multiplier bits, HI the running sum.
    // Divide: LO holds remaining dividend bits and collects quotient bits.
    always_comb begin
        hi_in     = acc_in[2*DATA_WIDTH-1:DATA_WIDTH];
        lo_in     = acc_in[DATA_WIDTH-1:0];
        mul_sum   = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : {(DATA_WIDTH+1){1'b0}});
        div_shift = {hi_in, lo_in[DATA_WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, operand});
        // When the divisor fits, the difference is below the divisor and fits in W bits.
        rem_sub   = div_shift[DATA_WIDTH-1:0] - operand;
        if (is_div) begin
            if (div_fits) begin
                acc_out = {rem_sub, lo_in[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {div_shift[DATA_WIDTH-1:0], lo_in[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {mul_sum, lo_in[DATA_WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : mdu_sequencer                                           |
// | Description : Iterative MULT/DIV sequencer owning the HI/LO registers  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  abort,
    input  logic                  hi_rd,
    input  logic                  lo_rd,
    input  logic                  hi_wr,
    input  logic                  lo_wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic                  stall_req
);

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

    mdu_op_t                 op_e;
    mdu_state_t              state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;
    logic                    is_div_q, is_div_d;
    logic                    neg_quo_q, neg_quo_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    div0_q, div0_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic                    done_q, done_d;
    logic                    div_zero_q, div_zero_d;

    logic                    op_div;
    logic                    op_signed;
    logic [DATA_WIDTH-1:0]   a_mag;
    logic [DATA_WIDTH-1:0]   b_mag;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix;
    logic [DATA_WIDTH-1:0]   rem_fix;

    assign op_e      = mdu_op_t'(op);
    assign op_div    = op_is_div(op_e);
    assign op_signed = op_is_signed(op_e);
    assign a_mag     = (op_signed && operand_a[DATA_WIDTH-1]) ? -operand_a : operand_a;
    assign b_mag     = (op_signed && operand_b[DATA_WIDTH-1]) ? -operand_b : operand_b;

    mdu_iter_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter_step (
        .acc_in  (acc_q),
        .operand (opnd_q),
        .is_div  (is_div_q),
        .acc_out (acc_step)
    );

    // Magnitude results are negated on the way into HI/LO.
    assign prod_fix = neg_quo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_quo_q ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                :  acc_q[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            MDU_IDLE: begin
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
                if (start && !abort) begin
                    cnt_d    = '0;
                    is_div_d = op_div;
                    if (op_div && (operand_b == '0)) begin
                        // Sign flags cleared so DONE passes the raw dividend into HI.
                        acc_d     = {operand_a, MDU_DIV0_LO[DATA_WIDTH-1:0]};
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        div0_d    = 1'b1;
                        state_d   = MDU_DONE;
                    end else begin
                        acc_d     = {{DATA_WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        opnd_d    = op_div ? b_mag : a_mag;
                        neg_quo_d = op_signed &&
                                    (operand_a[DATA_WIDTH-1] ^ operand_b[DATA_WIDTH-1]);
                        neg_rem_d = op_signed && op_div && operand_a[DATA_WIDTH-1];
                        div0_d    = 1'b0;
                        state_d   = MDU_RUN;
                    end
                end
            end
            MDU_RUN: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                end else begin
                    acc_d = acc_step;
                    if (cnt_q == LAST_ITER) begin
                        cnt_d   = '0;
                        state_d = MDU_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
                if (!abort) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    done_d     = 1'b1;
                    div_zero_d = div0_q;
                end
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MDU_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign busy      = (state_q != MDU_IDLE);
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign stall_req = busy && (start || hi_rd || lo_rd || hi_wr || lo_wr);

endmodule
`default_nettype wire
